// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end sitting directly upstream of EXECUTE. A PC
// generator issues in-order, word-aligned requests to a variable-latency
// instruction memory. Returned instructions are buffered with their PCs in a
// small prefetch FIFO and are handed to EXECUTE under a valid/ready handshake.
// A redirect (taken branch / jump target) flushes everything in flight.
//
// Handshakes:
//   - IMEM request: a request transfers on a rising edge where
//     imem_req && imem_gnt. While imem_req=1 and imem_gnt=0, imem_addr is
//     held. The only exception is a redirect, which withdraws the request.
//   - IMEM response: imem_rvalid is a one-cycle pulse per response. Responses
//     come back in request order.
//   - EXECUTE: an instruction transfers on a rising edge where
//     inst_valid && x_ready. inst_out and pc_out stay stable while
//     inst_valid=1 and x_ready=0.
//
// Parameters:
//   DEPTH            prefetch FIFO entries (power of two, >= 2)
//   MAX_OUTSTANDING  requests granted but not yet answered (1..DEPTH)
//   RESET_PC         first fetch address after reset
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous, active-low reset
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch address (word aligned)
//   imem_gnt     in   request accepted this cycle when imem_req=1
//   imem_rvalid  in   response valid (in request order)
//   imem_rdata   in   fetched instruction
//   redir_valid  in   redirect fetch this cycle
//   redir_pc     in   redirect target, bits [1:0] ignored
//   inst_valid   out  inst_out/pc_out hold a valid instruction
//   x_ready      in   EXECUTE accepts the instruction this cycle
//   inst_out     out  instruction to EXECUTE
//   pc_out       out  PC of inst_out
//   q_empty      out  FIFO holds no entries (status/debug)
//
// Optional feature:
//   FETCH_QUEUE_BYPASS_EN  When defined, a response arriving while the FIFO
//                          is empty (and nothing is stale, no redirect) is
//                          presented to EXECUTE in the same cycle. If it is
//                          accepted, it never enters the FIFO.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        inst_valid,
    input  logic        x_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        q_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    // occupancy + outstanding never exceeds 2*DEPTH, so one extra bit suffices
    localparam int SW = CW + 1;

    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] DEPTH_S   = SW'(DEPTH);
    localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUTSTANDING - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   fetch_pc_q, fetch_pc_d;

    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] stale_q, stale_d;

    // In-order PCs of granted, non-stale requests; the head belongs to the
    // next live response.
    logic [31:0]   tag_mem_q [MAX_OUTSTANDING];
    logic [TW-1:0] tag_rd_q, tag_rd_d;
    logic [TW-1:0] tag_wr_q, tag_wr_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic        fifo_empty;
    logic        req_fire;
    logic        resp_live;
    logic        resp_drop;
    logic        push;
    logic        pop;
    logic        bypass_take;
    logic [31:0] tag_head;
    logic [31:0] head_pc;
    logic [31:0] head_inst;
    logic [SW-1:0] credit_sum;

    // The target is forced to word alignment, so its low bits are unused.
    logic        unused_redir_lsb;
    assign unused_redir_lsb = ^redir_pc[1:0];

    assign fifo_empty = (count_q == '0);
    assign q_empty    = fifo_empty;
    assign tag_head   = tag_mem_q[tag_rd_q];
    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_inst  = inst_mem_q[rd_ptr_q];
    assign credit_sum = SW'(count_q) + SW'(out_q);

    // Every request reserves a FIFO slot up front, so a response can always
    // be pushed. Gating with rst keeps the request low while held in reset.
    assign imem_req  = rst && !redir_valid && (out_q < MAX_OUT_C) &&
                       (credit_sum < DEPTH_S);
    assign imem_addr = fetch_pc_q;
    assign req_fire  = imem_req && imem_gnt;

    // A response during a redirect is discarded; the redirect accounts for it
    // when computing the new stale count.
    assign resp_live = imem_rvalid && !redir_valid && (stale_q == '0);
    assign resp_drop = imem_rvalid && !redir_valid && (stale_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass      = fifo_empty && resp_live;
    assign bypass_take = bypass && x_ready;

    always_comb begin
        inst_valid = !fifo_empty && !redir_valid;
        inst_out   = head_inst;
        pc_out     = head_pc;
        if (bypass) begin
            inst_valid = 1'b1;
            inst_out   = imem_rdata;
            pc_out     = tag_head;
        end
    end
`else
    assign bypass_take = 1'b0;

    always_comb begin
        inst_valid = !fifo_empty && !redir_valid;
        inst_out   = head_inst;
        pc_out     = head_pc;
    end
`endif

    // Only a buffered entry is popped; a bypassed response is consumed
    // without touching the FIFO.
    assign pop  = !fifo_empty && !redir_valid && x_ready;
    assign push = resp_live && !bypass_take;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        if (p == TAG_LAST) begin
            return '0;
        end
        return p + TW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        stale_d    = stale_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;

        // Outstanding tracks the IMEM view and is unaffected by flushes.
        if (req_fire) begin
            out_d = out_d + OW'(1);
        end
        if (imem_rvalid && (out_q != '0)) begin
            out_d = out_d - OW'(1);
        end

        if (redir_valid) begin
            fetch_pc_d = {redir_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
            // No request fires during a redirect, so every request still in
            // flight after this cycle's response belongs to the old path.
            stale_d    = out_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tag_wr_d   = tag_inc(tag_wr_q);
            end
            if (resp_drop) begin
                stale_d = stale_q - OW'(1);
            end
            if (resp_live) begin
                tag_rd_d = tag_inc(tag_rd_q);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            stale_q    <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
            for (int j = 0; j < MAX_OUTSTANDING; j++) begin
                tag_mem_q[j] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            stale_q    <= stale_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            if (req_fire) begin
                tag_mem_q[tag_wr_q] <= fetch_pc_q;
            end
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= tag_head;
                inst_mem_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue with DEPTH=4, MAX_OUTSTANDING=2, RESET_PC=0
// in the default build (no bypass). A zero-wait IMEM model inside tick()
// records each granted address and, when enabled, returns ~addr as the
// instruction in the following cycle. Inputs change 1 time unit after the
// rising edge; outputs are checked 1 unit later.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        inst_valid;
  logic        x_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        q_empty;

  int checks = 0;
  int errors = 0;
  int grants_total;
  int grants_8;
  logic        resp_en;
  logic [31:0] pend_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH(4),
    .MAX_OUTSTANDING(2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redir_valid(redir_valid),
    .redir_pc(redir_pc),
    .inst_valid(inst_valid),
    .x_ready(x_ready),
    .inst_out(inst_out),
    .pc_out(pc_out),
    .q_empty(q_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: capture the grant seen before the edge, then drive the
  // response for the oldest pending request just after the edge.
  task automatic tick();
    logic [31:0] a;
    @(negedge clk);
    if (imem_req && imem_gnt) begin
      pend_q.push_back(imem_addr);
      grants_total++;
      if (imem_addr == 32'h8) grants_8++;
    end
    @(posedge clk);
    #1;
    if (resp_en && pend_q.size() != 0) begin
      a = pend_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = ~a;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  // Leaves rst asserted, 1 unit after a rising edge.
  task automatic do_reset();
    rst          = 1'b0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    redir_valid  = 1'b0;
    redir_pc     = '0;
    x_ready      = 1'b0;
    resp_en      = 1'b0;
    grants_total = 0;
    grants_8     = 0;
    pend_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    #2;

    // ---------------- reset values ----------------
    do_reset();
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_empty", q_empty, 1'b1);

    // ---------------- zero-wait stream, x_ready=1 ----------------
    imem_gnt = 1'b1;
    x_ready  = 1'b1;
    resp_en  = 1'b1;
    rst      = 1'b1;
    #1;
    chk("t1_req0", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid0", inst_valid, 1'b0);
    for (int k = 0; k < 7; k++) exp_q.push_back(32'(4 * k));
    for (int c = 1; c <= 8; c++) begin
      tick();
      #1;
      chk("t1_addr", imem_addr, 32'(4 * c));
      chk("t1_valid", inst_valid, (c >= 2) ? 1'b1 : 1'b0);
      if (inst_valid && x_ready && exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("t1_pc", pc_out, e);
        chk("t1_inst", inst_out, ~e);
      end
    end
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- backpressure, credits ----------------
    do_reset();
    #1;
    chk("t2_rst_empty", q_empty, 1'b1);
    chk("t2_rst_req", imem_req, 1'b0);
    imem_gnt = 1'b1;
    x_ready  = 1'b0;
    resp_en  = 1'b1;
    rst      = 1'b1;
    repeat (7) tick();
    #1;
    chk("t2_grants", 32'(grants_total), 32'd4);
    chk("t2_req", imem_req, 1'b0);
    chk("t2_addr", imem_addr, 32'h10);
    chk("t2_empty", q_empty, 1'b0);
    chk("t2_valid", inst_valid, 1'b1);
    chk("t2_pc", pc_out, 32'h0);
    chk("t2_inst", inst_out, 32'hFFFF_FFFF);
    tick();
    #1;
    chk("t2_pc_hold", pc_out, 32'h0);
    x_ready = 1'b1;
    #1;
    chk("t2_pop_valid", inst_valid, 1'b1);
    chk("t2_full_req", imem_req, 1'b0);
    tick();
    x_ready = 1'b0;
    #1;
    chk("t2_credit_req", imem_req, 1'b1);
    chk("t2_credit_addr", imem_addr, 32'h10);
    chk("t2_next_pc", pc_out, 32'h4);

    // ---------------- redirect with 2 outstanding ----------------
    do_reset();
    imem_gnt = 1'b1;
    x_ready  = 1'b1;
    resp_en  = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    #1;
    chk("t3_out_full", imem_req, 1'b0);
    chk("t3_empty", q_empty, 1'b1);
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0103;
    resp_en     = 1'b1;
    #1;
    chk("t3_redir_valid", inst_valid, 1'b0);
    chk("t3_redir_req", imem_req, 1'b0);
    tick();
    redir_valid = 1'b0;
    #1;
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_req_wait", imem_req, 1'b0);
    chk("t3_drop1", inst_valid, 1'b0);
    tick();
    #1;
    chk("t3_req", imem_req, 1'b1);
    chk("t3_addr2", imem_addr, 32'h100);
    chk("t3_drop2", inst_valid, 1'b0);
    tick();
    #1;
    chk("t3_addr3", imem_addr, 32'h104);
    chk("t3_none", inst_valid, 1'b0);
    chk("t3_none_empty", q_empty, 1'b1);
    tick();
    #1;
    chk("t3_valid", inst_valid, 1'b1);
    chk("t3_pc", pc_out, 32'h100);
    chk("t3_inst", inst_out, ~32'h100);

    // ---------------- grant held low ----------------
    do_reset();
    imem_gnt = 1'b1;
    x_ready  = 1'b1;
    resp_en  = 1'b1;
    rst      = 1'b1;
    tick();
    tick();
    imem_gnt = 1'b0;
    #1;
    chk("t4_addr_a", imem_addr, 32'h8);
    chk("t4_req_a", imem_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("t4_addr_hold", imem_addr, 32'h8);
      chk("t4_req_hold", imem_req, 1'b1);
    end
    imem_gnt = 1'b1;
    tick();
    #1;
    chk("t4_addr_next", imem_addr, 32'hC);
    tick();
    #1;
    chk("t4_grants8", 32'(grants_8), 32'd1);

    // ---------------- redirect with rvalid and would-be pop ----------------
    do_reset();
    imem_gnt = 1'b1;
    x_ready  = 1'b1;
    resp_en  = 1'b1;
    rst      = 1'b1;
    tick();
    tick();
    #1;
    chk("t5_pre_valid", inst_valid, 1'b1);
    chk("t5_pre_rvalid", imem_rvalid, 1'b1);
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0200;
    #1;
    chk("t5_valid", inst_valid, 1'b0);
    chk("t5_req", imem_req, 1'b0);
    tick();
    redir_valid = 1'b0;
    #1;
    chk("t5_empty", q_empty, 1'b1);
    chk("t5_valid_n1", inst_valid, 1'b0);
    chk("t5_req_n1", imem_req, 1'b1);
    chk("t5_addr_n1", imem_addr, 32'h200);
    tick();
    #1;
    chk("t5_valid_n2", inst_valid, 1'b0);
    tick();
    #1;
    chk("t5_valid_n3", inst_valid, 1'b1);
    chk("t5_pc", pc_out, 32'h200);

    // ---------------- PC wrap ----------------
    do_reset();
    imem_gnt    = 1'b1;
    x_ready     = 1'b1;
    resp_en     = 1'b1;
    redir_valid = 1'b1;
    redir_pc    = 32'hFFFF_FFFC;
    rst         = 1'b1;
    #1;
    chk("t6_redir_req", imem_req, 1'b0);
    tick();
    redir_valid = 1'b0;
    #1;
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t6_req", imem_req, 1'b1);
    tick();
    #1;
    chk("t6_addr_wrap", imem_addr, 32'h0);
    tick();
    #1;
    chk("t6_valid", inst_valid, 1'b1);
    chk("t6_pc", pc_out, 32'hFFFF_FFFC);
    chk("t6_inst", inst_out, 32'h0000_0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
